muldiv_arbiter: RTL and testbench

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

---
 rtl/muldiv_arbiter.sv | 136 +++++++++++++
 tb/tb_muldiv_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_arbiter.sv
// Arbitrates two issue slots onto one shared iterative mul/div unit. Operands are
// latched at grant, and each slot's result is held in a sticky flag until the pipe advances.
module muldiv_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [1:0]  req0_op,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    output logic        unit_start,
    output logic [1:0]  unit_op,
    output logic [31:0] unit_src1,
    output logic [31:0] unit_src2,
    input  logic        unit_done,
    input  logic [63:0] unit_res,
    output logic [63:0] res0,
    output logic [63:0] res1,
    output logic        done0,
    output logic        done1,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  unit_op_q;
    logic [31:0] unit_src1_q, unit_src2_q;
    logic        grant_q, last_grant_q;
    logic        winner, issue, capture;

    logic [1:0]  req_valid, pending, hit;
    logic [1:0]  op_in   [2];
    logic [31:0] src1_in [2];
    logic [31:0] src2_in [2];
    logic [63:0] res_q   [2];
    logic        done_q  [2];

    assign req_valid  = {req1_valid, req0_valid};
    assign op_in[0]   = req0_op;
    assign op_in[1]   = req1_op;
    assign src1_in[0] = req0_src1;
    assign src1_in[1] = req1_src1;
    assign src2_in[0] = req0_src2;
    assign src2_in[1] = req1_src2;

    // Reset and flush both mask the stall so the pipe is never held by stale requests.
    assign stallreq_o = ~resetn & ~flush & (|pending);

    // With a tie, round-robin grants the slot that did not receive the most recent grant.
    always_comb begin
        winner = 1'b0;
        if (pending[1] && (!pending[0] || (!PRIO_FIXED && !last_grant_q))) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!flush && (|pending)) state_d = S_ISSUE;
            S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (unit_done)  state_d = S_IDLE;
                else if (flush) state_d = S_DRAIN;
            end
            S_DRAIN: if (unit_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unit_start = (state_q == S_ISSUE);
        issue      = (state_q == S_IDLE) && (state_d == S_ISSUE);
        capture    = (state_q == S_WAIT) && unit_done && !flush;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            unit_op_q    <= '0;
            unit_src1_q  <= '0;
            unit_src2_q  <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (issue) begin
            unit_op_q    <= op_in[winner];
            unit_src1_q  <= src1_in[winner];
            unit_src2_q  <= src2_in[winner];
            grant_q      <= winner;
            last_grant_q <= winner;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign pending[gi] = req_valid[gi] & ~done_q[gi];
            assign hit[gi]     = capture & (grant_q == 1'(gi));

            // Clearing on pipe advance wins over a same-edge capture for a withdrawn request.
            always_ff @(posedge clk) begin
                if (resetn) begin
                    res_q[gi]  <= '0;
                    done_q[gi] <= 1'b0;
                end else begin
                    if (hit[gi]) res_q[gi] <= unit_res;
                    if (flush || !stallreq_o) done_q[gi] <= 1'b0;
                    else if (hit[gi])         done_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign unit_op   = unit_op_q;
    assign unit_src1 = unit_src1_q;
    assign unit_src2 = unit_src2_q;
    assign res0      = res_q[0];
    assign res1      = res_q[1];
    assign done0     = done_q[0];
    assign done1     = done_q[1];

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share one stimulus stream,
// each with its own latency-programmable mul/div unit model.
module tb_muldiv_arbiter;

    logic        clk;
    logic        resetn, flush;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;

    logic        a_unit_start, a_unit_done, a_done0, a_done1, a_stallreq_o;
    logic [1:0]  a_unit_op;
    logic [31:0] a_unit_src1, a_unit_src2;
    logic [63:0] a_unit_res, a_res0, a_res1;

    logic        b_unit_start, b_unit_done, b_done0, b_done1, b_stallreq_o;
    logic [1:0]  b_unit_op;
    logic [31:0] b_unit_src1, b_unit_src2;
    logic [63:0] b_unit_res, b_res0, b_res1;

    int tests = 0;
    int fails = 0;
    int unit_lat = 3;
    int m_cnt [2];
    bit m_busy [2];
    logic early;

    muldiv_arbiter #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .unit_start(a_unit_start), .unit_op(a_unit_op),
        .unit_src1(a_unit_src1), .unit_src2(a_unit_src2),
        .unit_done(a_unit_done), .unit_res(a_unit_res),
        .res0(a_res0), .res1(a_res1), .done0(a_done0), .done1(a_done1),
        .stallreq_o(a_stallreq_o)
    );

    muldiv_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .unit_start(b_unit_start), .unit_op(b_unit_op),
        .unit_src1(b_unit_src1), .unit_src2(b_unit_src2),
        .unit_done(b_unit_done), .unit_res(b_unit_res),
        .res0(b_res0), .res1(b_res1), .done0(b_done0), .done1(b_done1),
        .stallreq_o(b_stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00:   return {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b01:   return {32'h0, a} * {32'h0, b};
            2'b10:   return (b == 0) ? 64'h0 : {32'(sa % sb), 32'(sa / sb)};
            default: return (b == 0) ? 64'h0 : {a % b, a / b};
        endcase
    endfunction

    // Unit model: done pulses unit_lat cycles after start, computed from the operands the DUT holds then.
    task automatic model_step(input int k, input logic rst, input logic st, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              output logic done, output logic [63:0] res);
        done = 1'b0;
        res  = 64'h0;
        if (rst) begin
            m_busy[k] = 1'b0;
        end else begin
            if (m_busy[k]) begin
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) begin
                    m_busy[k] = 1'b0;
                    done      = 1'b1;
                    res       = calc(op, a, b);
                end
            end
            if (st) begin
                m_busy[k] = 1'b1;
                m_cnt[k]  = unit_lat;
            end
        end
    endtask

    initial begin
        a_unit_done = 1'b0; a_unit_res = '0;
        b_unit_done = 1'b0; b_unit_res = '0;
        m_busy[0] = 1'b0; m_busy[1] = 1'b0;
        forever begin
            @(negedge clk);
            model_step(0, resetn, a_unit_start, a_unit_op, a_unit_src1, a_unit_src2, a_unit_done, a_unit_res);
            model_step(1, resetn, b_unit_start, b_unit_op, b_unit_src1, b_unit_src2, b_unit_done, b_unit_res);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Both slots request at cycle 0 (unit latency 3); the first grant goes to a_first/b_first.
    task automatic run_pair(input string tag, input logic a_first, input logic b_first);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk({tag, "_stall0"}, a_stallreq_o, 1'b1);
        step();
        chk({tag, "_start1"}, a_unit_start, 1'b1);
        chk({tag, "_op1_rr"}, a_unit_op, {1'b0, a_first});
        chk({tag, "_op1_fx"}, b_unit_op, {1'b0, b_first});
        repeat (4) step();
        chk({tag, "_done5_rr"}, {a_done1, a_done0}, a_first ? 2'b10 : 2'b01);
        chk({tag, "_done5_fx"}, {b_done1, b_done0}, b_first ? 2'b10 : 2'b01);
        chk({tag, "_stall5"}, a_stallreq_o, 1'b1);
        step();
        chk({tag, "_start6"}, a_unit_start, 1'b1);
        chk({tag, "_op6_rr"}, a_unit_op, {1'b0, ~a_first});
        chk({tag, "_op6_fx"}, b_unit_op, {1'b0, ~b_first});
        repeat (4) step();
        chk({tag, "_done10_rr"}, {a_done1, a_done0}, 2'b11);
        chk({tag, "_done10_fx"}, {b_done1, b_done0}, 2'b11);
        chk({tag, "_res0"}, a_res0, 64'hFFFFFFFF_FFFFFFF1);
        chk({tag, "_res1"}, a_res1, 64'h00000000_00000010);
        chk({tag, "_stall10"}, a_stallreq_o, 1'b0);
    endtask

    initial begin
        resetn = 1'b1; flush = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = 2'b00; req1_op = 2'b00;
        req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
        step(); step();
        chk("rst_stall", a_stallreq_o, 1'b0);
        chk("rst_start", a_unit_start, 1'b0);
        chk("rst_op", a_unit_op, 2'b00);
        chk("rst_src1", a_unit_src1, 32'h0);
        chk("rst_src2", a_unit_src2, 32'h0);
        chk("rst_res0", a_res0, 64'h0);
        chk("rst_res1", a_res1, 64'h0);
        chk("rst_done", {a_done1, a_done0}, 2'b00);
        chk("rst_done_fx", {b_done1, b_done0}, 2'b00);

        // Single divu 100/7 with a 33-cycle unit; operands change while waiting.
        resetn = 1'b0; req0_valid = 1'b1; req0_op = 2'b11;
        req0_src1 = 32'd100; req0_src2 = 32'd7; unit_lat = 33;
        #1;
        chk("div_stall0", a_stallreq_o, 1'b1);
        chk("div_start0", a_unit_start, 1'b0);
        step();
        chk("div_start1", a_unit_start, 1'b1);
        chk("div_op", a_unit_op, 2'b11);
        chk("div_src1", a_unit_src1, 32'd100);
        chk("div_src2", a_unit_src2, 32'd7);
        step();
        req0_src1 = 32'd999; req0_src2 = 32'd1;
        repeat (32) step();
        chk("div_stall34", a_stallreq_o, 1'b1);
        chk("div_done34", a_done0, 1'b0);
        step();
        chk("div_res35", a_res0, 64'h00000002_0000000E);
        chk("div_done35", a_done0, 1'b1);
        chk("div_stall35", a_stallreq_o, 1'b0);
        req0_valid = 1'b0;
        step();
        chk("div_done_clr", a_done0, 1'b0);
        chk("div_res_hold", a_res0, 64'h00000002_0000000E);

        // Tie after reset, immediate repeat, then a tie following a lone slot-0 grant.
        resetn = 1'b1; unit_lat = 3;
        step(); step();
        resetn = 1'b0;
        req0_op = 2'b00; req0_src1 = 32'hFFFFFFFD; req0_src2 = 32'd5;
        req1_op = 2'b01; req1_src1 = 32'd4;        req1_src2 = 32'd4;
        run_pair("rr1", 1'b0, 1'b0);
        step();
        chk("rr1_clr", {a_done1, a_done0}, 2'b00);
        // The pointer follows every grant, so slot 1 closing the round hands the next tie to slot 0.
        run_pair("rr2", 1'b0, 1'b0);
        req1_valid = 1'b0;
        step();
        step();
        chk("solo_start", a_unit_start, 1'b1);
        chk("solo_op", a_unit_op, 2'b00);
        repeat (4) step();
        chk("solo_done", a_done0, 1'b1);
        chk("solo_stall", a_stallreq_o, 1'b0);
        req0_valid = 1'b0;
        step();
        run_pair("rr3", 1'b1, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Flush during the div's wait: drain without restarting, then reissue.
        req0_valid = 1'b1; req0_op = 2'b11; req0_src1 = 32'd100; req0_src2 = 32'd7;
        unit_lat = 33;
        step();
        chk("fl_start1", a_unit_start, 1'b1);
        repeat (9) step();
        flush = 1'b1;
        #1;
        chk("fl_stall", a_stallreq_o, 1'b0);
        step();
        flush = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (a_unit_start) early = 1'b1;
            step();
        end
        chk("fl_no_restart", early, 1'b0);
        chk("fl_done0", a_done0, 1'b0);
        chk("fl_res0", a_res0, 64'hFFFFFFFF_FFFFFFF1);
        unit_lat = 3;
        step();
        chk("fl_reissue", a_unit_start, 1'b1);

        // Flush coincident with unit_done: result dropped, straight back to IDLE.
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fd_done0", a_done0, 1'b0);
        chk("fd_res0", a_res0, 64'hFFFFFFFF_FFFFFFF1);
        chk("fd_start40", a_unit_start, 1'b0);
        step();
        chk("fd_start41", a_unit_start, 1'b1);

        // Reset while waiting, then a clean reissue.
        step();
        resetn = 1'b1;
        step();
        chk("rw_start", a_unit_start, 1'b0);
        chk("rw_op", a_unit_op, 2'b00);
        chk("rw_src1", a_unit_src1, 32'h0);
        chk("rw_src2", a_unit_src2, 32'h0);
        chk("rw_res0", a_res0, 64'h0);
        chk("rw_done0", a_done0, 1'b0);
        chk("rw_stall", a_stallreq_o, 1'b0);
        step();
        resetn = 1'b0;
        #1;
        chk("rw_stall0", a_stallreq_o, 1'b1);
        step();
        chk("rw_start1", a_unit_start, 1'b1);
        chk("rw_op1", a_unit_op, 2'b11);
        chk("rw_src1_1", a_unit_src1, 32'd100);
        repeat (4) step();
        chk("rw_res", a_res0, 64'h00000002_0000000E);
        chk("rw_done", a_done0, 1'b1);
        chk("rw_stall_end", a_stallreq_o, 1'b0);
        req0_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
